// File: rtl/cache_axi_bridge.sv
// Cache refill/writeback port to AXI4 master bridge: one outstanding read, one outstanding write.
// Define BRIDGE_RAW_LINE_CHECK_EN to block reads only on a same-line pending write.
module cache_axi_bridge #(
  parameter logic [3:0]  RD_ID      = 4'd0,
  parameter logic [3:0]  WR_ID      = 4'd1,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_req,
  output logic                      rd_rdy,
  input  logic [2:0]                rd_type,
  input  logic [31:0]               rd_addr,
  output logic                      ret_valid,
  output logic [1:0]                ret_last,
  output logic [31:0]               ret_data,
  input  logic                      wr_req,
  output logic                      wr_rdy,
  input  logic [2:0]                wr_type,
  input  logic [31:0]               wr_addr,
  input  logic [3:0]                wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]  wr_data,
  output logic [3:0]                arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [31:0]               rdata,
  input  logic                      rlast,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [3:0]                awid,
  output logic [31:0]               awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic                      bvalid,
  input  logic [1:0]                bresp,
  output logic                      bready
);
  localparam int unsigned CW       = $clog2(LINE_WORDS);
  localparam logic [7:0]  LINE_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wr_state_t;

  rd_state_t      rd_state, rd_nxt;
  wr_state_t      wr_state, wr_nxt;
  logic [CW-1:0]  wr_cnt, wr_cnt_nxt;
  logic [31:0]    rd_addr_q, wr_addr_q;
  logic [2:0]     rd_type_q, wr_type_q;
  logic [3:0]     wr_strb_q;
  logic [31:0]    wr_buf [LINE_WORDS];
  logic           rd_line, wr_line, last_beat, raw_block;
  logic           unused_resp;

  assign unused_resp = ^{rresp, bresp};

  assign rd_line   = (rd_type_q == 3'b100);
  assign wr_line   = (wr_type_q == 3'b100);
  assign last_beat = ~wr_line | (wr_cnt == CW'(LINE_WORDS - 1));

  assign arid    = RD_ID;
  assign araddr  = rd_line ? {rd_addr_q[31:4], 4'b0} : rd_addr_q;
  assign arlen   = rd_line ? LINE_LEN : '0;
  assign arsize  = rd_line ? 3'd2 : {1'b0, rd_type_q[1:0]};
  assign arburst = 2'b01;

  assign awid    = WR_ID;
  assign awaddr  = wr_line ? {wr_addr_q[31:4], 4'b0} : wr_addr_q;
  assign awlen   = wr_line ? LINE_LEN : '0;
  assign awsize  = wr_line ? 3'd2 : {1'b0, wr_type_q[1:0]};
  assign awburst = 2'b01;

  assign wdata = wr_buf[wr_cnt];
  assign wstrb = wr_line ? 4'hF : wr_strb_q;
  assign wlast = (wr_state == W_DATA) & last_beat;

  assign ret_valid = (rd_state == R_DATA) & rvalid;
  assign ret_data  = rdata;
  assign ret_last  = {1'b0, ret_valid & rlast};

  // A write accepted this very cycle already counts as pending, so a same-cycle
  // read can never be issued ahead of it.
`ifdef BRIDGE_RAW_LINE_CHECK_EN
  assign raw_block = ((wr_state != W_IDLE) && (rd_addr[31:4] == wr_addr_q[31:4])) ||
                     (wr_req && wr_rdy && (rd_addr[31:4] == wr_addr[31:4]));
`else
  assign raw_block = (wr_state != W_IDLE) || (wr_req && wr_rdy);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
    end else begin
      rd_state <= rd_nxt;
      wr_state <= wr_nxt;
      wr_cnt   <= wr_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_req && rd_rdy) begin
      rd_addr_q <= rd_addr;
      rd_type_q <= rd_type;
    end
    if (wr_req && wr_rdy) begin
      wr_addr_q <= wr_addr;
      wr_type_q <= wr_type;
      wr_strb_q <= wr_wstrb;
      for (int unsigned i = 0; i < LINE_WORDS; i++)
        wr_buf[i] <= wr_data[32*i +: 32];
    end
  end

  always_comb begin
    rd_nxt  = rd_state;
    rd_rdy  = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        rd_rdy = ~raw_block;
        if (rd_req && !raw_block) rd_nxt = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) rd_nxt = R_IDLE;
      end
      default: rd_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    wr_nxt     = wr_state;
    wr_cnt_nxt = wr_cnt;
    wr_rdy     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (wr_state)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) wr_nxt = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wr_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready) begin
          if (last_beat) begin
            wr_nxt     = W_B;
            wr_cnt_nxt = '0;
          end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
          end
        end
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) wr_nxt = W_IDLE;
      end
      default: wr_nxt = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: bench drives the AXI slave side by hand, step by step.
// Expected RAW behaviour follows BRIDGE_RAW_LINE_CHECK_EN when defined.
module tb_cache_axi_bridge;
  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req, rd_rdy, ret_valid;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr, ret_data;
  logic [1:0]   ret_last;
  logic         wr_req, wr_rdy;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic [3:0]   arid, awid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  int ntests = 0;
  int nfail  = 0;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_type(rd_type), .rd_addr(rd_addr),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_rdy(wr_rdy), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_wstrb(wr_wstrb), .wr_data(wr_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues a write and leaves the bench settled in the AW phase.
  task automatic wr_issue(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                          input logic [127:0] d, input logic [31:0] exp_awaddr,
                          input logic [7:0] exp_awlen, input logic [2:0] exp_awsize);
    tick();
    wr_req = 1'b1; wr_addr = a; wr_type = t; wr_wstrb = s; wr_data = d;
    settle();
    chk("wr_rdy_idle", wr_rdy, 1'b1);
    tick();
    wr_req = 1'b0;
    settle();
    chk("awvalid", awvalid, 1'b1);
    chk("awaddr", awaddr, exp_awaddr);
    chk("awlen", awlen, exp_awlen);
    chk("awsize", awsize, exp_awsize);
    chk("awid", awid, 4'd1);
    chk("no_w_before_aw", wvalid, 1'b0);
    chk("wr_rdy_busy", wr_rdy, 1'b0);
  endtask

  // Completes a single-beat write from the AW phase, checking rd_rdy at each stage.
  task automatic wr_finish(input logic exp_rd_rdy);
    settle();
    chk("fin_awvalid", awvalid, 1'b1);
    chk("fin_rd_rdy_aw", rd_rdy, exp_rd_rdy);
    awready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b1;
    settle();
    chk("fin_wvalid", wvalid, 1'b1);
    chk("fin_wlast", wlast, 1'b1);
    chk("fin_rd_rdy_w", rd_rdy, exp_rd_rdy);
    tick();
    wready = 1'b0;
    settle();
    chk("fin_bready", bready, 1'b1);
    chk("fin_rd_rdy_b", rd_rdy, exp_rd_rdy);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
  endtask

  // Completes a single-beat read from the AR phase.
  task automatic rd_finish(input logic [31:0] exp_araddr, input logic [31:0] d);
    settle();
    chk("rf_arvalid", arvalid, 1'b1);
    chk("rf_araddr", araddr, exp_araddr);
    chk("rf_arlen", arlen, 8'd0);
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = d;
    settle();
    chk("rf_ret_valid", ret_valid, 1'b1);
    chk("rf_ret_data", ret_data, d);
    chk("rf_ret_last", ret_last, 2'b01);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rd_req = 1'b0; rd_type = '0; rd_addr = '0;
    wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    tick();
    tick();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_ret_valid", ret_valid, 1'b0);
    chk("rst_rd_rdy", rd_rdy, 1'b1);
    chk("rst_wr_rdy", wr_rdy, 1'b1);
    reset = 1'b0;

    // Line read, arready after two cycles, four beats.
    tick();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C00_0040;
    settle();
    chk("lr_rd_rdy", rd_rdy, 1'b1);
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("lr_arvalid", arvalid, 1'b1);
      chk("lr_araddr", araddr, 32'h1C00_0040);
      chk("lr_arlen", arlen, 8'd3);
      chk("lr_arsize", arsize, 3'd2);
      chk("lr_rd_rdy_busy", rd_rdy, 1'b0);
      tick();
    end
    arready = 1'b1;
    settle();
    chk("lr_arvalid_hs", arvalid, 1'b1);
    chk("lr_arid", arid, 4'd0);
    tick();
    arready = 1'b0;
    settle();
    chk("lr_rready", rready, 1'b1);
    chk("lr_arvalid_off", arvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rdata = 32'(i); rlast = (i == 3);
      settle();
      chk("lr_ret_valid", ret_valid, 1'b1);
      chk("lr_ret_data", ret_data, 32'(i));
      chk("lr_ret_last", ret_last, (i == 3) ? 2'b01 : 2'b00);
      chk("lr_rd_rdy_data", rd_rdy, 1'b0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    settle();
    chk("lr_rd_rdy_back", rd_rdy, 1'b1);
    chk("lr_rready_off", rready, 1'b0);

    // Line write, four beats, bready held until bvalid.
    wr_issue(32'h0000_1230, 3'b100, 4'h0, {32'd4, 32'd3, 32'd2, 32'd1},
             32'h0000_1230, 8'd3, 3'd2);
    awready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("lw_wvalid", wvalid, 1'b1);
      chk("lw_wdata", wdata, 32'(i + 1));
      chk("lw_wstrb", wstrb, 4'hF);
      chk("lw_wlast", wlast, i == 3);
      tick();
    end
    wready = 1'b0;
    settle();
    chk("lw_wvalid_off", wvalid, 1'b0);
    chk("lw_bready", bready, 1'b1);
    tick();
    chk("lw_bready_hold", bready, 1'b1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    settle();
    chk("lw_bready_off", bready, 1'b0);
    chk("lw_wr_rdy", wr_rdy, 1'b1);

    // Line write with wready low for three cycles after the first beat.
    wr_issue(32'h0000_0048, 3'b100, 4'h0, {32'hD, 32'hC, 32'hB, 32'hA},
             32'h0000_0040, 8'd3, 3'd2);
    awready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b1;
    settle();
    chk("st_wdata0", wdata, 32'hA);
    tick();
    wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("st_wvalid", wvalid, 1'b1);
      chk("st_wdata_hold", wdata, 32'hB);
      chk("st_wstrb_hold", wstrb, 4'hF);
      chk("st_wlast_hold", wlast, 1'b0);
      tick();
    end
    wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("st_wdata", wdata, 32'hB + 32'(i));
      chk("st_wlast", wlast, i == 2);
      tick();
    end
    wready = 1'b0; bvalid = 1'b1;
    settle();
    chk("st_bready", bready, 1'b1);
    tick();
    bvalid = 1'b0;

    // Word write with partial strobe.
    wr_issue(32'hBFAF_F004, 3'b010, 4'b0011, {96'h0, 32'hCAFE_F00D},
             32'hBFAF_F004, 8'd0, 3'd2);
    awready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b1;
    settle();
    chk("ww_wdata", wdata, 32'hCAFE_F00D);
    chk("ww_wstrb", wstrb, 4'b0011);
    chk("ww_wlast", wlast, 1'b1);
    tick();
    wready = 1'b0; bvalid = 1'b1;
    tick();
    bvalid = 1'b0;

    // Same-line read behind a pending write stays blocked until the write completes.
    wr_issue(32'h0000_0100, 3'b010, 4'hF, {96'h0, 32'h1111_1111},
             32'h0000_0100, 8'd0, 3'd2);
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_0108;
    settle();
    chk("raw_same_blk", rd_rdy, 1'b0);
    wr_finish(1'b0);
    settle();
    chk("raw_same_release", rd_rdy, 1'b1);
    tick();
    rd_req = 1'b0;
    rd_finish(32'h0000_0108, 32'h5555_AAAA);

    // Read to a different line while a write is pending.
    wr_issue(32'h0000_0100, 3'b010, 4'hF, {96'h0, 32'h2222_2222},
             32'h0000_0100, 8'd0, 3'd2);
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_0200;
    settle();
`ifdef BRIDGE_RAW_LINE_CHECK_EN
    chk("raw_other_accept", rd_rdy, 1'b1);
    tick();
    rd_req = 1'b0;
    rd_finish(32'h0000_0200, 32'h0BAD_BEEF);
    wr_finish(1'b1);
`else
    chk("raw_other_blk", rd_rdy, 1'b0);
    wr_finish(1'b0);
    settle();
    chk("raw_other_release", rd_rdy, 1'b1);
    tick();
    rd_req = 1'b0;
    rd_finish(32'h0000_0200, 32'h0BAD_BEEF);
`endif

    // Write accepted in the same cycle as a same-line read blocks that read.
    tick();
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_0304; wr_wstrb = 4'hF;
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_0300;
    settle();
    chk("raw_same_cycle_blk", rd_rdy, 1'b0);
    chk("raw_same_cycle_wr", wr_rdy, 1'b1);
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    wr_finish(1'b0);

    // Reset during beat 2 of a line read, with a write also in flight.
    tick();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0800;
    tick();
    rd_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    wr_issue(32'h0000_0500, 3'b010, 4'hF, {96'h0, 32'h3333_3333},
             32'h0000_0500, 8'd0, 3'd2);
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'h100 + 32'(i);
      settle();
      chk("rr_ret_data", ret_data, 32'h100 + 32'(i));
      tick();
    end
    rdata = 32'h102;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rr_rready", rready, 1'b0);
    chk("rr_ret_valid", ret_valid, 1'b0);
    chk("rr_rd_rdy", rd_rdy, 1'b1);
    chk("rr_wr_rdy", wr_rdy, 1'b1);
    chk("rr_awvalid", awvalid, 1'b0);
    rvalid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
